// File: rtl/noc_out_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC output virtual channel
// among NUM_PORTS local requesters, with a registered output stage.
module noc_out_packet_arbiter #(
  parameter int FLIT_WIDTH = 34,
  parameter int NUM_PORTS  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, LOCKED} state_t;
  typedef logic [PTR_W-1:0] ptr_t;

  state_t                state_q, state_d;
  ptr_t                  rr_q, rr_d;
  ptr_t                  owner_q, owner_d;
  ptr_t                  sel;
  ptr_t                  cand;
  int                    idx;
  logic                  sel_valid;
  logic                  sel_ends;
  logic                  load;
  logic                  xfer;
  logic [FLIT_WIDTH-1:0] sel_flit;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(NUM_PORTS - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign load = !out_valid || out_ready;
  assign busy = (state_q == LOCKED);

  // Source selection: the packet owner while locked, otherwise the first
  // valid requester at or after rr.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    sel       = owner_q;
    sel_valid = in_valid[owner_q];
    cand      = '0;
    idx       = 0;
    if (state_q == IDLE) begin
      sel       = rr_q;
      sel_valid = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        cand = ptr_t'(idx);
        if (!sel_valid && in_valid[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == ptr_t'(i)) sel_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // LAST (2'b10) and SINGLE (2'b11) are exactly the types with the type MSB set.
  assign sel_ends = sel_flit[FLIT_WIDTH-1];
  assign xfer     = sel_valid && load;

  always_comb begin
    in_ready = '0;
    grant    = '0;
    if (xfer) in_ready[sel] = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = busy && (owner_q == ptr_t'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_ends) begin
            rr_d = ptr_inc(sel);
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_ends) begin
          state_d = IDLE;
          rr_d    = ptr_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) out_flit <= sel_flit;
    end
  end

endmodule

// File: tb/tb_noc_out_packet_arbiter.sv
// Scoreboard bench for noc_out_packet_arbiter: expected flits are queued in
// service order as packets are offered and compared as the output accepts them.
module tb_noc_out_packet_arbiter;

  localparam int FW = 34;
  localparam int NP = 3;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_PAY  = 2'b00;
  localparam logic [1:0] T_LAST = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic             clk;
  logic             rst_n;
  logic [NP*FW-1:0] in_flit;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_ready;
  logic [FW-1:0]    out_flit;
  logic             out_valid;
  logic             out_ready;
  logic [NP-1:0]    grant;
  logic             busy;

  logic [FW-1:0] src_q [NP][$];
  logic [FW-1:0] sb_q [$];
  logic [NP-1:0] stall;
  logic          ds_ready;
  logic [FW-1:0] exp_flit;
  logic [FW-1:0] hold_flit;
  int n_checks, n_fail, cyc, out_count, first_out, last_out, n_steps;

  noc_out_packet_arbiter #(.FLIT_WIDTH(FW), .NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int port, input int tag, input int seq);
    return {t, 16'h0, 8'(tag), 4'(port), 4'(seq)};
  endfunction

  // Offers a packet on one port and records its flits as the next expected output.
  task automatic send_pkt(input int port, input int len, input int tag);
    logic [1:0]    t;
    logic [FW-1:0] f;
    for (int k = 0; k < len; k++) begin
      if (len == 1)          t = T_SGL;
      else if (k == 0)       t = T_HDR;
      else if (k == len - 1) t = T_LAST;
      else                   t = T_PAY;
      f = mk(t, port, tag, k);
      src_q[port].push_back(f);
      sb_q.push_back(f);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NP; i++) src_q[i].delete();
    sb_q.delete();
    in_valid  = '0;
    in_flit   = '0;
    stall     = '0;
    ds_ready  = 1'b1;
    out_ready = 1'b1;
    out_count = 0;
    first_out = -1;
    last_out  = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at the falling edge, then observe what the next rising edge will accept.
  task automatic step();
    @(negedge clk);
    out_ready = ds_ready;
    for (int i = 0; i < NP; i++) begin
      in_valid[i]          = (src_q[i].size() > 0) && !stall[i];
      in_flit[i*FW +: FW]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    #1;
    cyc++;
    check("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", out_flit, '0);
      end else begin
        exp_flit = sb_q.pop_front();
        check("out_flit", out_flit, exp_flit);
      end
      out_count++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    for (int i = 0; i < NP; i++) begin
      if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic drain(input string tag);
    int src_left;
    n_steps = 0;
    ds_ready = 1'b1;
    while ((sb_q.size() > 0 || out_valid) && n_steps < 200) begin
      step();
      n_steps++;
    end
    check({tag, "_timeout"}, 64'(n_steps < 200), 64'd1);
    src_left = 0;
    for (int i = 0; i < NP; i++) src_left += src_q[i].size();
    check({tag, "_src_left"}, 64'(src_left), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;

    // Reset values, then one 3-flit packet from port 0.
    do_reset();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    send_pkt(0, 3, 1);
    step();
    check("t1_grant_idle", 64'(grant), 64'd0);
    step();
    check("t1_grant_c1", 64'(grant), 64'b001);
    check("t1_busy_c1", 64'(busy), 64'd1);
    step();
    check("t1_grant_c2", 64'(grant), 64'b001);
    step();
    check("t1_grant_end", 64'(grant), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);
    drain("t1");
    check("t1_out_count", 64'(out_count), 64'd3);
    check("t1_no_bubble", 64'(last_out - first_out + 1), 64'(out_count));

    // Ports 0 and 2 together: no interleave, no gap; rr wraps back to 0.
    do_reset();
    send_pkt(0, 3, 2);
    send_pkt(2, 3, 3);
    drain("t2");
    check("t2_out_count", 64'(out_count), 64'd6);
    check("t2_no_bubble", 64'(last_out - first_out + 1), 64'(out_count));
    send_pkt(0, 1, 4);
    send_pkt(1, 1, 5);
    drain("t2_rr");

    // Backpressure after the second flit.
    do_reset();
    send_pkt(0, 3, 6);
    hold_flit = mk(T_PAY, 0, 6, 1);
    step();
    step();
    ds_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_flit", 64'(out_flit), 64'(hold_flit));
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_in_ready", 64'(in_ready), 64'd0);
    end
    drain("t3");
    check("t3_out_count", 64'(out_count), 64'd3);

    // All ports streaming SINGLE flits: strict rotation, full throughput.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NP; p++) send_pkt(p, 1, 16 + r);
    end
    drain("t4");
    check("t4_out_count", 64'(out_count), 64'd9);
    check("t4_no_bubble", 64'(last_out - first_out + 1), 64'(out_count));

    // Asynchronous reset in the middle of a port-1 packet.
    do_reset();
    src_q[1].push_back(mk(T_HDR, 1, 32, 0));
    src_q[1].push_back(mk(T_PAY, 1, 32, 1));
    src_q[1].push_back(mk(T_PAY, 1, 32, 2));
    src_q[1].push_back(mk(T_LAST, 1, 32, 3));
    sb_q.push_back(mk(T_HDR, 1, 32, 0));
    sb_q.push_back(mk(T_PAY, 1, 32, 1));
    repeat (3) step();
    check("t5_pre_busy", 64'(busy), 64'd1);
    check("t5_pre_grant", 64'(grant), 64'b010);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_grant", 64'(grant), 64'd0);
    check("t5_sb_consumed", 64'(sb_q.size()), 64'd0);
    do_reset();
    send_pkt(0, 1, 33);
    send_pkt(1, 1, 34);
    drain("t5_after");

    // Owner stalls mid-packet while another port waits.
    do_reset();
    send_pkt(1, 3, 40);
    send_pkt(2, 1, 41);
    step();
    step();
    stall[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_in_ready2", 64'(in_ready[2]), 64'd0);
      check("t6_grant", 64'(grant), 64'b010);
    end
    stall[1] = 1'b0;
    drain("t6");
    check("t6_out_count", 64'(out_count), 64'd4);

    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
